// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
//
// Purpose : arbiter state encoding and constants shared by the UART modules.
// Contents: uart_arb_state_t (ARB, TAG, SEND, ACK, DONE), UART_TAG_PREFIX,
//           UART_MAX_REQ.
package uart_pkg;

  typedef enum logic [2:0] {
    ARB  = 3'd0,
    TAG  = 3'd1,
    SEND = 3'd2,
    ACK  = 3'd3,
    DONE = 3'd4
  } uart_arb_state_t;

  // Source tag byte is this prefix OR'd with the requester index.
  localparam logic [7:0] UART_TAG_PREFIX = 8'hF0;

  // Largest requester count any arbiter in this path supports.
  localparam int UART_MAX_REQ = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search
//
// Purpose : returns the first asserted request at or after ptr, wrapping
//           modulo N.
// Ports   : req_i   [N-1:0]  request vector
//           ptr_i   [W-1:0]  highest-priority index
//           idx_o   [W-1:0]  selected index (0 when nothing is found)
//           found_o          any request asserted
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Walk the N candidates in priority order; the first hit wins.
    for (int k = 0; k < N; k++) begin
      int c;
      c = (int'(ptr_i) + k) % N;
      if (!found_o && req_i[c]) begin
        found_o = 1'b1;
        idx_o   = W'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level round-robin arbiter in front of uart_tx
//
// Purpose : shares one uart_tx serializer among NUM_REQ byte streams. An owner
//           keeps the serializer until it sends a byte flagged last, so
//           packets never interleave.
// Config  : UART_ARB_TAG_EN - when defined, every packet is preceded on the
//           wire by the tag byte 8'hF0 | grant_id.
// Ports   : clk, rstn (synchronous, active-low)
//           req_valid [NUM_REQ]     requester i presents a byte
//           req_data  [8*NUM_REQ]   packed request bytes
//           req_last  [NUM_REQ]     byte ends the packet
//           req_ready [NUM_REQ]     one-cycle pulse, byte consumed (owner only)
//           tx_sdata  [8]           byte to uart_tx
//           tx_start                one-cycle start pulse to uart_tx
//           tx_busy                 uart_tx busy status
//           grant_valid             a requester owns the serializer
//           grant_id  [ID_W]        owner index
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_sdata,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id
);

  uart_arb_state_t    state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic [7:0]         tx_sdata_q, tx_sdata_d;
  logic               tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               last_q, last_d;

  logic [ID_W-1:0]    pick_idx;
  logic               pick_found;

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ARB;
      ptr_q         <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      tx_sdata_q    <= '0;
      tx_start_q    <= 1'b0;
      req_ready_q   <= '0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      tx_sdata_q    <= tx_sdata_d;
      tx_start_q    <= tx_start_d;
      req_ready_q   <= req_ready_d;
      last_q        <= last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    tx_sdata_d    = tx_sdata_q;
    tx_start_d    = 1'b0;
    req_ready_d   = '0;
    last_d        = last_q;

    unique case (state_q)
      ARB: begin
        if (pick_found) begin
          grant_id_d    = pick_idx;
          grant_valid_d = 1'b1;
`ifdef UART_ARB_TAG_EN
          state_d       = TAG;
`else
          state_d       = SEND;
`endif
        end
      end

`ifdef UART_ARB_TAG_EN
      TAG: begin
        if (!tx_busy) begin
          tx_sdata_d = UART_TAG_PREFIX | 8'(grant_id_q);
          tx_start_d = 1'b1;
          // The tag never ends a packet; the payload still has to follow.
          last_d     = 1'b0;
          state_d    = ACK;
        end
      end
`endif

      SEND: begin
        if (req_valid[grant_id_q] && !tx_busy) begin
          tx_sdata_d              = req_data[{grant_id_q, 3'b000} +: 8];
          tx_start_d              = 1'b1;
          req_ready_d[grant_id_q] = 1'b1;
          last_d                  = req_last[grant_id_q];
          state_d                 = ACK;
        end
      end

      // Wait for uart_tx to acknowledge the start pulse before watching for
      // the end of the byte, otherwise the pre-start idle would end it early.
      ACK: begin
        if (tx_busy) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_valid_d = 1'b0;
            ptr_d         = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
            state_d       = ARB;
          end else begin
            state_d = SEND;
          end
        end
      end

      default: state_d = ARB;
    endcase
  end

  assign req_ready   = req_ready_q;
  assign tx_sdata    = tx_sdata_q;
  assign tx_start    = tx_start_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares one `uart_tx` serializer among `NUM_REQ` byte-stream requesters. It sits between the requesters (debug printer, core output port, loader status, and so on) and the single `uart_tx` instance. It drives `uart_tx`'s `sdata`/`tx_start` and observes its `tx_busy`. A granted requester keeps the serializer until it sends a byte marked `last`, so multi-byte messages are never interleaved.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `grant_id`; derived, never overridden.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ: requester i has a byte on `req_data[8*i+:8]`.
- `req_data`  in  8*NUM_REQ: packed request bytes.
- `req_last`  in  NUM_REQ: the byte is the final byte of the packet.
- `req_ready`  out  NUM_REQ: one-cycle pulse; the byte of requester i was consumed.
- `tx_sdata`  out  8: to `uart_tx.sdata`.
- `tx_start`  out  1: to `uart_tx.tx_start`; one-cycle pulse.
- `tx_busy`  in  1: from `uart_tx.tx_busy`.
- `grant_valid`  out  1: a requester currently owns the serializer.
- `grant_id`  out  ID_W: index of the owner; meaningful only when `grant_valid` is high.

## Operation
- All outputs are registered.
- Reset values:
  - `req_ready`=0, `tx_sdata`=0, `tx_start`=0, `grant_valid`=0, `grant_id`=0.
  - Round-robin pointer = 0, so requester 0 has first priority after reset.
  - State = ARB.
- States:
  - **ARB**: no owner.
    - If any `req_valid` is high, pick the first requester at or after the pointer, wrapping modulo `NUM_REQ`.
    - Set `grant_id` to it and `grant_valid`=1.
    - Go to TAG when `UART_ARB_TAG_EN` is defined, otherwise to SEND.
    - If no `req_valid` is high, stay in ARB.
  - **SEND**: wait for `req_valid[owner]` and `!tx_busy`. When both hold:
    - `tx_sdata` ← owner byte, `tx_start`=1, `req_ready[owner]`=1.
    - Latch `req_last[owner]` into `last_q`.
    - Go to ACK.
  - **ACK**: wait for `tx_busy`=1, then go to DONE.
  - **DONE**: wait for `tx_busy`=0.
    - If `last_q` is set: `grant_valid`=0, pointer ← (owner+1) mod `NUM_REQ`, go to ARB.
    - Otherwise go back to SEND.
- Requester rule: hold `req_data`/`req_last` stable while `req_valid` is high, until `req_ready` is sampled high.
  - The arbiter never samples `req_valid` in ACK or DONE, so the stale `req_valid` seen during the `req_ready` cycle is harmless.
- Requests from requesters other than the owner are ignored until the owner sends its `last` byte.
- If the owner drops `req_valid` mid-packet, the grant is held indefinitely. There is no timeout.
- Only the owner ever sees `req_ready`. At most one `req_ready` bit is high in any cycle.
- Reset mid-transfer aborts immediately and returns all outputs to their reset values.
  - The bench resets `uart_tx` on the same `rstn`.

## Timing
- From `req_valid` sampled high in ARB to `tx_start` high: 2 cycles. Edge 1 sets the grant; edge 2 issues the byte.
- `uart_tx` raises `tx_busy` 1 cycle after `tx_start`, so ACK normally lasts 1 cycle.
- Byte-to-byte gap inside a packet: `tx_start` rises 2 cycles after `tx_busy` falls (DONE→SEND, then SEND→issue).
- Packet-to-packet gap when another requester is waiting: ARB adds 1 cycle, so `tx_start` rises 3 cycles after `tx_busy` falls.
- Fairness: the owner index advances after every packet. A requester that is continuously valid is served within `NUM_REQ`-1 packets.

## Configuration
- `UART_ARB_TAG_EN` defined:
  - A TAG state follows ARB.
  - TAG waits for `!tx_busy`, then issues the byte `8'hF0 | grant_id` with `tx_start`=1 and no `req_ready`.
  - It then follows the ACK and DONE handshake and proceeds to SEND.
  - `last_q` is forced to 0 for the tag byte.
  - Each packet on the wire is preceded by its source tag.
- Not defined: the TAG state and its logic are absent, and ARB goes directly to SEND.

## Structure
- Shared package `uart_pkg`:
  - State enum `uart_arb_state_t` (ARB, TAG, SEND, ACK, DONE).
  - `UART_TAG_PREFIX` = 8'hF0.
  - `UART_MAX_REQ` = 8.
- One natural sub-module: `rr_pick`.
  - Combinational round-robin search: `req_valid` and pointer in; index and found out.
  - Reusable by other arbiters in the design.

## Test plan
Bench instantiates the real `uart_tx` with `CLK_PER_HALF_BIT`=2 and a serial receiver model.
- Single request: requester 0 sends 8'h55 with `last` → `tx_start` at cycle +2, wire carries 0x55, `req_ready[0]` pulses exactly once, `grant_valid` falls after stop bit.
- Packet lock: requester 1 sends 3 bytes 01,02,03 (`last` on 03) while requester 2 is valid with 0xAA → wire order 01,02,03,AA; no interleave.
- Round-robin: all 4 requesters continuously valid with 1-byte packets (0x10+i) → wire order 10,11,12,13,10,… and `grant_id` sequence 0,1,2,3,0.
- Mid-packet stall: requester 3 drops `req_valid` after its first byte for 50 cycles → `grant_valid` stays 1, `grant_id`=3, no other requester is served, resumes on re-assert.
- Reset mid-byte: `rstn`=0 for 1 cycle during DONE → all outputs at reset values next cycle, pointer=0, `txd` idle high.
- With `UART_ARB_TAG_EN`: requester 2 sends 0x7E → wire carries F2 then 7E; `req_ready[2]` pulses only for the 7E byte.
